// File: rtl/softshell_pkg.sv
// Shared definitions for the softshell interconnect: Wishbone widths, arbiter FSM encoding,
// and the default stall budget before a hung slave transfer is aborted.
package softshell_pkg;

  localparam int WB_AW = 32;
  localparam int WB_DW = 32;
  localparam int WB_SW = 4;

  localparam int TIMEOUT_CYCLES_DEFAULT = 255;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    OWN      = 2'd1,
    ERR_WAIT = 2'd2
  } arb_state_t;

endpackage

// File: rtl/softshell_rr_pick.sv
// Combinational round-robin picker: first asserted req scanning upward from last+1, wrapping.
// Zero latency; no state, so the caller owns the 'last' pointer and the handshake.
module softshell_rr_pick #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic [IW-1:0] winner,
  output logic          vld
);

  logic [IW-1:0] idx;

  // Scan farthest-first so the nearest requester after 'last' overwrites and wins.
  always_comb begin
    winner = '0;
    vld    = 1'b0;
    idx    = '0;
    for (int i = N; i >= 1; i--) begin
      idx = IW'((int'(last) + i) % N);
      if (req[idx]) begin
        winner = idx;
        vld    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/softshell_wb_arbiter.sv
// Round-robin Wishbone classic arbiter: whole-cyc bus lock, one-cycle registered grant latency,
// combinational ack/data pass-through; a slave stalling past TIMEOUT_CYCLES is aborted with err.
module softshell_wb_arbiter
  import softshell_pkg::*;
#(
  parameter int NUM_MASTERS    = 4,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
  input  logic                         wb_clk_i,
  input  logic                         wb_rst_i,
  input  logic [NUM_MASTERS-1:0]       m_cyc_i,
  input  logic [NUM_MASTERS-1:0]       m_stb_i,
  input  logic [NUM_MASTERS-1:0]       m_we_i,
  input  logic [WB_SW*NUM_MASTERS-1:0] m_sel_i,
  input  logic [WB_AW*NUM_MASTERS-1:0] m_adr_i,
  input  logic [WB_DW*NUM_MASTERS-1:0] m_dat_i,
  output logic [NUM_MASTERS-1:0]       m_ack_o,
  output logic [NUM_MASTERS-1:0]       m_err_o,
  output logic [WB_DW-1:0]             m_dat_o,
  output logic                         s_cyc_o,
  output logic                         s_stb_o,
  output logic                         s_we_o,
  output logic [WB_SW-1:0]             s_sel_o,
  output logic [WB_AW-1:0]             s_adr_o,
  output logic [WB_DW-1:0]             s_dat_o,
  input  logic                         s_ack_i,
  input  logic [WB_DW-1:0]             s_dat_i,
  output logic [NUM_MASTERS-1:0]       grant_o,
  output logic                         timeout_o
);

  localparam int IW = $clog2(NUM_MASTERS);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  arb_state_t             state;
  logic [IW-1:0]          owner;
  logic [IW-1:0]          last;
  logic [NUM_MASTERS-1:0] grant;
  logic [CW-1:0]          cnt;

  logic [IW-1:0]          pick_idx;
  logic                   pick_vld;

  logic                   own_cyc, own_stb, own_we;
  logic [WB_SW-1:0]       own_sel;
  logic [WB_AW-1:0]       own_adr;
  logic [WB_DW-1:0]       own_dat;
  logic [NUM_MASTERS-1:0] own_hot;

  logic active, pass_data, ack_fwd, tmo_hit;

  softshell_rr_pick #(.N(NUM_MASTERS), .IW(IW)) u_pick (
    .req    (m_cyc_i),
    .last   (last),
    .winner (pick_idx),
    .vld    (pick_vld)
  );

  always_comb begin
    own_cyc = 1'b0;
    own_stb = 1'b0;
    own_we  = 1'b0;
    own_sel = '0;
    own_adr = '0;
    own_dat = '0;
    own_hot = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (owner == IW'(i)) begin
        own_cyc    = m_cyc_i[i];
        own_stb    = m_stb_i[i];
        own_we     = m_we_i[i];
        own_sel    = m_sel_i[i*WB_SW +: WB_SW];
        own_adr    = m_adr_i[i*WB_AW +: WB_AW];
        own_dat    = m_dat_i[i*WB_DW +: WB_DW];
        own_hot[i] = 1'b1;
      end
    end
  end

  // Reset masks everything combinationally so a slave ack coinciding with reset never leaks out.
  assign active    = (state == OWN) && !wb_rst_i;
  assign pass_data = (state != IDLE) && !wb_rst_i;
  assign ack_fwd   = active && s_ack_i && own_cyc && own_stb;
  assign tmo_hit   = active && own_cyc && own_stb && !s_ack_i && (cnt == CW'(TIMEOUT_CYCLES));

  assign s_cyc_o   = active && own_cyc;
  assign s_stb_o   = active && own_stb;
  assign s_we_o    = active && own_we;
  assign s_sel_o   = pass_data ? own_sel : '0;
  assign s_adr_o   = pass_data ? own_adr : '0;
  assign s_dat_o   = pass_data ? own_dat : '0;

  assign m_ack_o   = ack_fwd ? own_hot : '0;
  assign m_err_o   = tmo_hit ? own_hot : '0;
  assign timeout_o = tmo_hit;
  assign m_dat_o   = s_dat_i;
  assign grant_o   = grant;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state <= IDLE;
      owner <= '0;
      last  <= IW'(NUM_MASTERS - 1);
      grant <= '0;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          cnt <= '0;
          if (pick_vld) begin
            owner <= pick_idx;
            grant <= NUM_MASTERS'(1) << pick_idx;
            state <= OWN;
          end
        end
        OWN: begin
          if (!own_cyc) begin
            last  <= owner;
            grant <= '0;
            cnt   <= '0;
            state <= IDLE;
          end else if (tmo_hit) begin
            cnt   <= '0;
            state <= ERR_WAIT;
          end else if (own_stb && !s_ack_i) begin
            if (cnt != CW'(TIMEOUT_CYCLES)) cnt <= cnt + 1'b1;
          end else begin
            cnt <= '0;
          end
        end
        ERR_WAIT: begin
          cnt <= '0;
          if (!own_cyc) begin
            last  <= owner;
            grant <= '0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
